uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmitter (50 MHz, 115200 baud serializer) among NUM_REQ byte-stream requesters.
- Round-robin arbitration at packet granularity: the winner keeps the transmitter until its last byte is accepted or it stalls past a timeout.
- Sits between the message sources (status, debug, echo logic) and the UART serializer; it drives the serializer's valid/ready byte input.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 50000, consecutive cycles a granted requester may hold req_valid low mid-packet before forced release; 0 disables the timeout.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid.
- req_ready  out  NUM_REQ  per-requester byte accepted this cycle.
- tx_valid  out  1  byte valid to serializer.
- tx_data  out  8  byte to serializer.
- tx_ready  in  1  serializer idle and accepting a byte.
- grant_valid  out  1  a requester currently owns the transmitter.
- grant_id  out  clog2(NUM_REQ)  current or most recent owner.
- timeout_err  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async assert, sync release): state IDLE; grant_valid=0; grant_id=0; rr_last=NUM_REQ-1, so requester 0 has top priority first; timeout counter=0; timeout_err=0.
- Outputs during reset: req_ready=0 and tx_valid=0.
- States: IDLE and LOCKED.
- IDLE:
  - tx_valid=0 and all req_ready=0.
  - If any req_valid is high, select the first set bit searching from rr_last+1 upward, with wrap-around.
  - Register the winner into grant_id, set grant_valid=1, and go to LOCKED on the next edge. Grant latency is 1 cycle.
- LOCKED, with owner o = grant_id:
  - tx_valid=req_valid[o] and tx_data=req_data[o], combinational pass-through.
  - req_ready[o]=tx_ready. Every other req_ready is 0.
  - A transfer occurs when tx_valid && tx_ready.
  - On a transfer with req_last[o]=1: go to IDLE, rr_last<=o, grant_valid<=0. grant_id holds its value.
  - At least one IDLE cycle separates consecutive packets.
- Timeout counter:
  - Resets to 0 on entering LOCKED and on every cycle with req_valid[o]=1.
  - Increments while req_valid[o]=0.
  - tx_ready low with req_valid[o] high does not count; backpressure never times out.
  - When the count reaches TIMEOUT_CYCLES (nonzero): go to IDLE, rr_last<=o, grant_valid<=0, and pulse timeout_err for exactly 1 cycle.
- Request changes: requesters that raise or drop req_valid while not granted have no effect until the next IDLE evaluation. No preemption.
- Multiple simultaneous requests: exactly one winner per the round-robin order. Losers see req_ready=0 and must hold their byte.
- Reset mid-packet: the packet is aborted immediately and tx_valid drops asynchronously. Requesters must restart the packet after reset.
- Counter width: clog2(TIMEOUT_CYCLES+1) with a minimum of 1 bit. The counter saturates and never wraps.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (IDLE, LOCKED);
  - localparams for NUM_REQ bounds and the clog2 id width;
  - the 50 MHz / 115200 baud constants shared with the serializer (CLKS_PER_BIT=434).
- Sub-module rr_pick: combinational round-robin priority picker. Inputs are the request vector and rr_last. Outputs are the winner id and any_req.
- FSM, timeout counter and muxing live in uart_tx_arbiter.

Test Plan:
- Single packet, tx_ready always 1: req0 sends 0x41, 0x42, 0x43 (last on 0x43).
  - Required: grant_valid rises 1 cycle after req_valid.
  - Required: tx_data shows 0x41/0x42/0x43 on consecutive cycles.
  - Required: back in IDLE after the 0x43 transfer.
- Contention: req0 and req2 both assert 1-byte packets 0x10 and 0x20 at the same cycle from reset.
  - Required: 0x10 is sent first (grant_id=0), then 0x20 (grant_id=2).
  - Required: repeating both requests gives order 0 then 2 again, since rr_last=2 puts 0 first.
- Lock and backpressure: req1 holds a 2-byte packet with tx_ready low for 434 cycles per byte, while req3 asserts throughout.
  - Required: req_ready[3] stays 0 until req1's last byte.
  - Required: no timeout_err.
- Timeout: TIMEOUT_CYCLES=8; req0 sends 1 byte without last, then drops req_valid.
  - Required: exactly 8 cycles later, timeout_err pulses once and grant_valid goes to 0.
  - Required: a pending req1 is granted on the next IDLE evaluation.
- Reset mid-packet: assert rst_n=0 during byte 2 of a 4-byte packet.
  - Required: tx_valid, req_ready and grant_valid are 0 immediately, without a clock edge.
  - Required: after release, requester 0 has top priority again.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  // Width helper that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  localparam int ID_W_MAX = clog2_min1(NUM_REQ_MAX);

  localparam int CLK_HZ       = 50_000_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and serializer byte streams plus grant status
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_arb_pkg::*;

  localparam int ID_W = clog2_min1(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 timeout_err;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant_valid, grant_id, timeout_err
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant_valid, grant_id, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker
// Searches upward from rr_last_i+1 with wrap-around and returns the first requester found.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_last_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               any_req_o
);

  logic [ID_W-1:0] idx;

  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_last_i) + k) % NUM_REQ);
      if (!any_req_o && req_i[idx]) begin
        any_req_o = 1'b1;
        winner_o  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin sharing of one UART serializer
// The owner keeps the serializer until its last byte is accepted or it idles past the timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic                clk,
  input logic                rst_n,
  uart_tx_arbiter_if.slave   bus
);

  localparam int              ID_W   = clog2_min1(NUM_REQ);
  localparam int              CNT_W  = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam bit              TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e       state_q;
  logic             grant_valid_q;
  logic             timeout_err_q;
  logic [ID_W-1:0]  grant_id_q;
  logic [ID_W-1:0]  rr_last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [ID_W-1:0]    winner;
  logic               any_req;
  logic               locked;
  logic               own_valid;
  logic               own_last;
  logic [7:0]         own_data;
  logic [NUM_REQ-1:0] ready;
  logic               last_xfer;
  logic               timeout_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i     (bus.req_valid),
    .rr_last_i (rr_last_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  assign locked = (state_q == LOCKED);

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id_q) begin
        own_valid = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_data  = bus.req_data[8*i +: 8];
        ready[i]  = locked && bus.tx_ready;
      end
    end
  end

  // Stall counter saturates rather than wrapping back below the threshold.
  assign cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign last_xfer   = locked && own_valid && bus.tx_ready && own_last;
  assign timeout_hit = TO_EN && locked && !own_valid && (cnt_d == TO_VAL);

  assign bus.tx_valid    = locked && own_valid;
  assign bus.tx_data     = own_data;
  assign bus.req_ready   = ready;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.timeout_err = timeout_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_last_q     <= ID_W'(NUM_REQ - 1);
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q       <= LOCKED;
            grant_id_q    <= winner;
            grant_valid_q <= 1'b1;
            cnt_q         <= '0;
          end
        end
        LOCKED: begin
          if (last_xfer || timeout_hit) begin
            state_q       <= IDLE;
            rr_last_q     <= grant_id_q;
            grant_valid_q <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= timeout_hit;
          end else if (own_valid) begin
            cnt_q <= '0;
          end else if (TO_EN) begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and randomized bench with a cycle-level reference model
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NR-1:0]     rv;
  logic [NR-1:0]     rl;
  logic [8*NR-1:0]   rd_flat;
  logic              tx_rdy;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

  assign bus.req_valid = rv;
  assign bus.req_last  = rl;
  assign bus.req_data  = rd_flat;
  assign bus.tx_ready  = tx_rdy;

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  int        m_owner;
  int        m_prev;
  int        m_gid;
  int        m_stall;
  bit        m_terr;
  logic [NR-1:0] acc;

  logic [8:0] q [NR][$];
  int         gap [NR];
  bit         rand_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_prev  = NR - 1;
    m_gid   = 0;
    m_stall = 0;
    m_terr  = 1'b0;
    acc     = '0;
  endtask

  task automatic sample();
    logic [NR-1:0] exp_rdy;
    bit            exp_tv;
    int            o;
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
      chk("rst_tx_valid", bus.tx_valid, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_grant_valid", bus.grant_valid, 0);
      chk("rst_grant_id", bus.grant_id, 0);
      chk("rst_timeout_err", bus.timeout_err, 0);
    end else begin
      o       = m_owner;
      exp_tv  = 1'b0;
      exp_rdy = '0;
      if (o >= 0) begin
        exp_tv = rv[o];
        if (tx_rdy) exp_rdy[o] = 1'b1;
      end
      chk("grant_valid", bus.grant_valid, (o >= 0));
      chk("grant_id", bus.grant_id, m_gid);
      chk("timeout_err", bus.timeout_err, m_terr);
      chk("tx_valid", bus.tx_valid, exp_tv);
      chk("req_ready", bus.req_ready, exp_rdy);
      if (exp_tv) chk("tx_data", bus.tx_data, rd_flat[8*o +: 8]);
      acc    = exp_rdy & rv;
      m_terr = 1'b0;
      if (o < 0) begin
        for (int k = 1; k <= NR; k++) begin
          int idx;
          idx = (m_prev + k) % NR;
          if (m_owner < 0 && rv[idx]) begin
            m_owner = idx;
            m_gid   = idx;
            m_stall = 0;
          end
        end
      end else if (rv[o] && tx_rdy && rl[o]) begin
        m_prev  = o;
        m_owner = -1;
      end else if (!rv[o]) begin
        m_stall++;
        if (TO > 0 && m_stall >= TO) begin
          m_prev  = o;
          m_owner = -1;
          m_terr  = 1'b1;
        end
      end else begin
        m_stall = 0;
      end
    end
  endtask

  task automatic present(input int i);
    logic [8:0] e;
    e = q[i].pop_front();
    rv[i] = 1'b1;
    rl[i] = e[8];
    rd_flat[8*i +: 8] = e[7:0];
  endtask

  task automatic drive_step();
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        rv[i] = 1'b0;
        if (q[i].size() > 0) begin
          if (rand_en && $urandom_range(0, 5) == 0) gap[i] = $urandom_range(1, 12);
          else present(i);
        end
      end else if (!rv[i]) begin
        if (gap[i] > 0) begin
          gap[i]--;
          if (gap[i] == 0 && q[i].size() > 0) present(i);
        end else if (q[i].size() > 0) begin
          present(i);
        end else if (rand_en && $urandom_range(0, 3) == 0) begin
          int n;
          n = $urandom_range(1, 4);
          for (int j = 0; j < n; j++) q[i].push_back({(j == n - 1), 8'($urandom)});
          present(i);
        end
      end
    end
    acc = '0;
    if (rand_en) tx_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic step_in();
    @(posedge clk);
    #1;
    drive_step();
  endtask

  task automatic tick();
    sample();
    step_in();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      q[i].delete();
      gap[i] = 0;
    end
    rv = '0;
    rl = '0;
    rd_flat = '0;
    acc = '0;
    sample();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    rv      = '0;
    rl      = '0;
    rd_flat = '0;
    tx_rdy  = 1'b1;
    rand_en = 1'b0;
    for (int i = 0; i < NR; i++) gap[i] = 0;
    model_reset();
    sample();
    sample();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single packet from requester 0
    q[0].push_back({1'b0, 8'h41});
    q[0].push_back({1'b0, 8'h42});
    q[0].push_back({1'b1, 8'h43});
    drive_step();
    sample(); chk("t1_no_grant_yet", bus.grant_valid, 0); step_in();
    sample(); chk("t1_grant", bus.grant_valid, 1); chk("t1_b0", bus.tx_data, 8'h41); step_in();
    sample(); chk("t1_b1", bus.tx_data, 8'h42); step_in();
    sample(); chk("t1_b2", bus.tx_data, 8'h43); chk("t1_b2_valid", bus.tx_valid, 1); step_in();
    sample(); chk("t1_idle", bus.grant_valid, 0); chk("t1_id_hold", bus.grant_id, 0); step_in();

    // contention between requesters 0 and 2, twice
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      q[0].push_back({1'b1, 8'h10});
      q[2].push_back({1'b1, 8'h20});
      drive_step();
      sample(); chk("t2_idle0", bus.grant_valid, 0); step_in();
      sample(); chk("t2_first_id", bus.grant_id, 0); chk("t2_first_data", bus.tx_data, 8'h10); step_in();
      sample(); step_in();
      sample(); chk("t2_second_id", bus.grant_id, 2); chk("t2_second_data", bus.tx_data, 8'h20); step_in();
      sample(); chk("t2_idle1", bus.grant_valid, 0); step_in();
    end

    // requester 1 under long backpressure while requester 3 waits
    tx_rdy = 1'b0;
    q[1].push_back({1'b0, 8'hA1});
    q[1].push_back({1'b1, 8'hA2});
    drive_step();
    tick();
    q[3].push_back({1'b1, 8'hB3});
    drive_step();
    for (int b = 0; b < 2; b++) begin
      repeat (uart_arb_pkg::CLKS_PER_BIT) begin
        sample();
        chk("t3_req3_ready", bus.req_ready[3], 0);
        chk("t3_owner", bus.grant_id, 1);
        chk("t3_no_timeout", bus.timeout_err, 0);
        step_in();
      end
      tx_rdy = 1'b1;
      sample(); chk("t3_xfer_ready1", bus.req_ready[1], 1); step_in();
      tx_rdy = 1'b0;
    end
    tx_rdy = 1'b1;
    repeat (6) tick();

    // owner 0 stalls after one byte; requester 1 waits
    q[0].push_back({1'b0, 8'h55});
    q[1].push_back({1'b1, 8'h66});
    drive_step();
    tick();
    sample(); chk("t4_owner0", bus.grant_id, 0); chk("t4_data", bus.tx_data, 8'h55); step_in();
    repeat (TO) begin
      sample(); chk("t4_held", bus.grant_valid, 1); chk("t4_no_pulse", bus.timeout_err, 0); step_in();
    end
    sample(); chk("t4_pulse", bus.timeout_err, 1); chk("t4_released", bus.grant_valid, 0); step_in();
    sample(); chk("t4_next_owner", bus.grant_id, 1); chk("t4_pulse_done", bus.timeout_err, 0);
    chk("t4_next_data", bus.tx_data, 8'h66); step_in();
    tick();

    // reset in the middle of a 4-byte packet from requester 2
    for (int j = 0; j < 4; j++) q[2].push_back({(j == 3), 8'hC0 + 8'(j)});
    drive_step();
    tick();
    tick();
    #2;
    chk("t5_pre_valid", bus.tx_valid, 1);
    chk("t5_pre_data", bus.tx_data, 8'hC1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_tx_valid", bus.tx_valid, 0);
    chk("t5_async_req_ready", bus.req_ready, 0);
    chk("t5_async_grant", bus.grant_valid, 0);
    do_reset();
    q[0].push_back({1'b1, 8'hD0});
    q[2].push_back({1'b1, 8'hD2});
    q[3].push_back({1'b1, 8'hD3});
    drive_step();
    tick();
    sample(); chk("t5_prio0", bus.grant_id, 0); chk("t5_prio0_data", bus.tx_data, 8'hD0); step_in();
    repeat (10) tick();

    // randomized traffic with random backpressure and stalls
    rand_en = 1'b1;
    repeat (3000) tick();
    rand_en = 1'b0;
    tx_rdy  = 1'b1;
    repeat (150) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
